see_cone_campaign: RTL and testbench
====================================

Name: see_cone_campaign

Overview:
- Parametrised fault-injection campaign controller for one extracted logic cone (Cone_* netlists).
- Drives pseudo-random input vectors to a golden cone instance and a faulty cone instance, selects and enables a single injection site in the faulty copy, and compares the two outputs.
- Counts propagated errors per injection site and reports per-node results plus a campaign total.
- Sits between the cone pair and the SEE analysis readout; the cone logic itself is external.

Parameters:
- N_IN, 5, cone input count; vector and LFSR width (legal 2..16).
- N_NODE, 5, injection sites in the faulty cone (legal >=1).
- SEL_W, $clog2(N_NODE) (min 1), width of the injection select and node index.
- VEC_W, 16, width of the per-node vector count.
- CNT_W, 16, width of the error counters (saturating).
- LAT, 0, pipeline latency of the cone pair in cycles (0 = combinational).

Ports:
- clk  in  1  single rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin campaign; sampled only in IDLE.
- abort  in  1  return to IDLE at the next edge from any state; no done pulse.
- seed  in  N_IN  LFSR seed, loaded at every node start.
- num_vec  in  VEC_W  vectors per node; sampled in LOAD.
- vec_o  out  N_IN  vector to both cones.
- inj_en  out  1  fault enable to the faulty cone.
- inj_sel  out  SEL_W  active injection site.
- golden_i  in  1  golden cone output.
- faulty_i  in  1  faulty cone output.
- busy  out  1  high in all states except IDLE.
- node_valid  out  1  one-cycle pulse carrying a per-node result.
- node_idx  out  SEL_W  node of the current result.
- node_err  out  CNT_W  mismatches for that node.
- total_err  out  CNT_W  running total, saturating; held after done.
- done  out  1  one-cycle pulse at campaign end.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; all outputs 0, including total_err, vec_o, inj_sel and counters. Reset mid-campaign discards all progress.
- FSM states: IDLE, LOAD, APPLY, WAIT, COMPARE, REPORT, DONE.
- IDLE -> LOAD when start=1. start while busy is ignored.
- LOAD (1 cycle):
  - Latch num_vec; node=0; LFSR<=seed; clear node and total counters.
  - Next state is APPLY, or REPORT if num_vec==0.
- APPLY (1 cycle):
  - Drive vec_o=LFSR; inj_en=1; inj_sel=node.
  - Next state is WAIT if LAT>0, else COMPARE.
- WAIT: LAT cycles, vec_o held.
- COMPARE (1 cycle):
  - Sample golden_i^faulty_i; if 1, increment node and total counters, each saturating at 2^CNT_W-1.
  - Advance LFSR; increment vector count.
  - Next state is APPLY, or REPORT once the count reaches num_vec.
- Per-vector cost is LAT+2 cycles.
- inj_en is high from APPLY through COMPARE and 0 in IDLE, LOAD, REPORT and DONE.
- REPORT (1 cycle):
  - node_valid=1, node_idx=node, node_err=final count.
  - Reseed LFSR, clear node counter and vector count, increment node.
  - Next state is APPLY (or REPORT again if num_vec==0) while nodes remain; otherwise DONE.
- DONE (1 cycle): done=1 -> IDLE.
- LFSR: Fibonacci, maximal length, fixed tap table per N_IN (N_IN=5: x^5+x^3+1).
  - An all-zero seed is replaced by all-ones.
  - Vectors repeat when num_vec > 2^N_IN-1; this is legal.
- abort takes priority over every transition; rst_n takes priority over abort.
- Campaign length with num_vec>0: done is high in cycle 1+N_NODE*(num_vec*(LAT+2)+1)+1 after start is sampled.

Test Plan:
- N_IN=5, N_NODE=5, LAT=0, num_vec=3, faulty_i tied to golden_i, start -> five node_valid pulses with node_idx 0..4, node_err=0, total_err=0, done in cycle 37, busy=1 in cycles 1..37.
- Same config, faulty_i=~golden_i -> each node_err=3, total_err=15; inj_sel steps 0..4.
- seed=5'b00000 -> first vec_o=5'b11111; the vec_o sequence is identical for every node.
- num_vec=0 -> five consecutive node_valid pulses with node_err=0, then done; inj_en never asserted.
- CNT_W=4, num_vec=20, always mismatch -> node_err=15 for every node, total_err=15 (saturated).
- LAT=2, abort asserted mid-node 2 -> IDLE next cycle, busy=0, no done pulse; a new start restarts at node 0 with total_err=0.
- rst_n=0 for one edge mid-campaign -> all outputs 0 the next cycle, FSM in IDLE.

Source files
------------

// File: rtl/see_cone_campaign.sv
// Fault-injection campaign controller for one extracted logic cone: drives LFSR
// vectors to a golden/faulty cone pair, walks the injection sites and counts mismatches.
module see_cone_campaign #(
  parameter int N_IN   = 5,
  parameter int N_NODE = 5,
  parameter int SEL_W  = (N_NODE > 1) ? $clog2(N_NODE) : 1,
  parameter int VEC_W  = 16,
  parameter int CNT_W  = 16,
  parameter int LAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  seed,
  input  logic [VEC_W-1:0] num_vec,
  output logic [N_IN-1:0]  vec_o,
  output logic             inj_en,
  output logic [SEL_W-1:0] inj_sel,
  input  logic             golden_i,
  input  logic             faulty_i,
  output logic             busy,
  output logic             node_valid,
  output logic [SEL_W-1:0] node_idx,
  output logic [CNT_W-1:0] node_err,
  output logic [CNT_W-1:0] total_err,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_APPLY, S_WAIT, S_COMPARE, S_REPORT, S_DONE
  } state_t;

  // Maximal-length tap sets; bit k-1 set for polynomial term x^k.
  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      2:       tap_mask = 16'h0003;
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0003;
    endcase
  endfunction

  localparam logic [15:0]      TAP_ALL   = tap_mask(N_IN);
  localparam logic [N_IN-1:0]  TAPS      = TAP_ALL[N_IN-1:0];
  localparam int               LAT_W     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_NODE = SEL_W'(N_NODE - 1);

  state_t             state_q, state_d;
  logic [N_IN-1:0]    lfsr_q, lfsr_d;
  logic [VEC_W-1:0]   num_vec_q, num_vec_d;
  logic [VEC_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [SEL_W-1:0]   node_q, node_d;
  logic [CNT_W-1:0]   node_cnt_q, node_cnt_d;
  logic [CNT_W-1:0]   tot_q, tot_d;
  logic [LAT_W-1:0]   wait_q, wait_d;
  logic [N_IN-1:0]    seed_fix;

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
  assign seed_fix = (seed == '0) ? '1 : seed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= '0;
      num_vec_q  <= '0;
      vec_cnt_q  <= '0;
      node_q     <= '0;
      node_cnt_q <= '0;
      tot_q      <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      num_vec_q  <= num_vec_d;
      vec_cnt_q  <= vec_cnt_d;
      node_q     <= node_d;
      node_cnt_q <= node_cnt_d;
      tot_q      <= tot_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    num_vec_d  = num_vec_q;
    vec_cnt_d  = vec_cnt_q;
    node_d     = node_q;
    node_cnt_d = node_cnt_q;
    tot_d      = tot_q;
    wait_d     = wait_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        num_vec_d  = num_vec;
        node_d     = '0;
        lfsr_d     = seed_fix;
        node_cnt_d = '0;
        tot_d      = '0;
        vec_cnt_d  = '0;
        state_d    = (num_vec == '0) ? S_REPORT : S_APPLY;
      end
      S_APPLY: begin
        wait_d  = '0;
        state_d = (LAT > 0) ? S_WAIT : S_COMPARE;
      end
      S_WAIT: begin
        if (wait_q == LAT_LAST) state_d = S_COMPARE;
        else                    wait_d  = wait_q + LAT_W'(1);
      end
      S_COMPARE: begin
        if (golden_i ^ faulty_i) begin
          if (node_cnt_q != '1) node_cnt_d = node_cnt_q + CNT_W'(1);
          if (tot_q != '1)      tot_d      = tot_q + CNT_W'(1);
        end
        lfsr_d    = {lfsr_q[N_IN-2:0], ^(lfsr_q & TAPS)};
        vec_cnt_d = vec_cnt_q + VEC_W'(1);
        state_d   = (vec_cnt_d == num_vec_q) ? S_REPORT : S_APPLY;
      end
      S_REPORT: begin
        lfsr_d     = seed_fix;
        node_cnt_d = '0;
        vec_cnt_d  = '0;
        if (node_q == LAST_NODE) begin
          state_d = S_DONE;
        end else begin
          node_d  = node_q + SEL_W'(1);
          state_d = (num_vec_q == '0) ? S_REPORT : S_APPLY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  assign busy       = (state_q != S_IDLE);
  assign inj_en     = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_COMPARE);
  assign vec_o      = inj_en ? lfsr_q : '0;
  assign inj_sel    = node_q;
  assign node_valid = (state_q == S_REPORT);
  assign node_idx   = node_valid ? node_q : '0;
  assign node_err   = node_valid ? node_cnt_q : '0;
  assign total_err  = tot_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_see_cone_campaign.sv
// Directed bench for see_cone_campaign: three configurations (default, 4-bit counters,
// two-cycle cone latency) driven by a behavioural cone whose faulty copy can be forced to mismatch.
module tb_see_cone_campaign;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, abort, flip;
  logic [4:0]  seed;
  logic [15:0] num_vec;
  logic        start_a, start_b, start_c;

  logic [4:0]  vec_a, vec_b, vec_c;
  logic        inj_a, inj_b, inj_c;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic        gold_a, gold_b, gold_c, fault_a, fault_b, fault_c;
  logic        busy_a, busy_b, busy_c, nv_a, nv_b, nv_c, done_a, done_b, done_c;
  logic [2:0]  idx_a, idx_b, idx_c;
  logic [15:0] nerr_a, terr_a, nerr_c, terr_c;
  logic [3:0]  nerr_b, terr_b;

  // Cone model: parity of the vector; faulty copy inverts while injection is on and flip=1.
  assign gold_a  = ^vec_a;
  assign gold_b  = ^vec_b;
  assign gold_c  = ^vec_c;
  assign fault_a = gold_a ^ (flip & inj_a);
  assign fault_b = gold_b ^ (flip & inj_b);
  assign fault_c = gold_c ^ (flip & inj_c);

  see_cone_campaign u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .seed(seed), .num_vec(num_vec),
    .vec_o(vec_a), .inj_en(inj_a), .inj_sel(sel_a), .golden_i(gold_a), .faulty_i(fault_a),
    .busy(busy_a), .node_valid(nv_a), .node_idx(idx_a), .node_err(nerr_a),
    .total_err(terr_a), .done(done_a)
  );

  see_cone_campaign #(.CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .seed(seed), .num_vec(num_vec),
    .vec_o(vec_b), .inj_en(inj_b), .inj_sel(sel_b), .golden_i(gold_b), .faulty_i(fault_b),
    .busy(busy_b), .node_valid(nv_b), .node_idx(idx_b), .node_err(nerr_b),
    .total_err(terr_b), .done(done_b)
  );

  see_cone_campaign #(.LAT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort), .seed(seed), .num_vec(num_vec),
    .vec_o(vec_c), .inj_en(inj_c), .inj_sel(sel_c), .golden_i(gold_c), .faulty_i(fault_c),
    .busy(busy_c), .node_valid(nv_c), .node_idx(idx_c), .node_err(nerr_c),
    .total_err(terr_c), .done(done_c)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int done_cyc, pulses, idx_bad, err_bad, inj_seen, vec_bad, busy_bad, sel_bad, node_inj;
  logic [4:0] exp_vec [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Runs one campaign on u_a, tallying anomalies cycle by cycle until done or max_cyc.
  task automatic run_a(input int max_cyc, input logic [15:0] exp_nerr);
    done_cyc = 0; pulses = 0; idx_bad = 0; err_bad = 0; inj_seen = 0;
    vec_bad = 0; busy_bad = 0; sel_bad = 0; node_inj = 0;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= max_cyc && done_cyc == 0; cyc++) begin
      tick();
      start_a = 1'b0;
      if (busy_a !== 1'b1) busy_bad++;
      if (inj_a === 1'b1) begin
        inj_seen++;
        if (sel_a !== 3'(pulses)) sel_bad++;
        if ((node_inj >> 1) < 3 && vec_a !== exp_vec[node_inj >> 1]) vec_bad++;
        node_inj++;
      end
      if (nv_a === 1'b1) begin
        if (idx_a !== 3'(pulses)) idx_bad++;
        if (nerr_a !== exp_nerr) err_bad++;
        pulses++;
        node_inj = 0;
      end
      if (done_a === 1'b1) done_cyc = cyc;
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_vec"},  32'(vec_a), 0);
    check({tag, "_inj"},  32'(inj_a), 0);
    check({tag, "_sel"},  32'(sel_a), 0);
    check({tag, "_busy"}, 32'(busy_a), 0);
    check({tag, "_nv"},   32'(nv_a), 0);
    check({tag, "_nerr"}, 32'(nerr_a), 0);
    check({tag, "_terr"}, 32'(terr_a), 0);
    check({tag, "_done"}, 32'(done_a), 0);
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; flip = 1'b0; seed = 5'b10101; num_vec = 16'd3;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    tick(); tick();
    check_zero_a("rst");
    check("rst_busy_c", 32'(busy_c), 0);
    rst_n = 1'b1;
    tick();

    // No mismatches: five clean node reports, done in cycle 37.
    exp_vec[0] = 5'b10101; exp_vec[1] = 5'b01010; exp_vec[2] = 5'b10100;
    run_a(60, 16'd0);
    check("t1_done_cyc", 32'(done_cyc), 37);
    check("t1_pulses",   32'(pulses), 5);
    check("t1_idx_bad",  32'(idx_bad), 0);
    check("t1_err_bad",  32'(err_bad), 0);
    check("t1_busy_bad", 32'(busy_bad), 0);
    check("t1_vec_bad",  32'(vec_bad), 0);
    check("t1_inj_seen", 32'(inj_seen), 30);
    check("t1_terr",     32'(terr_a), 0);
    tick();
    check("t1_busy_after", 32'(busy_a), 0);
    check("t1_done_pulse", 32'(done_a), 0);

    // Always mismatch, zero seed replaced by all-ones.
    flip = 1'b1; seed = 5'b00000;
    exp_vec[0] = 5'b11111; exp_vec[1] = 5'b11110; exp_vec[2] = 5'b11100;
    run_a(60, 16'd3);
    check("t2_done_cyc", 32'(done_cyc), 37);
    check("t2_pulses",   32'(pulses), 5);
    check("t2_idx_bad",  32'(idx_bad), 0);
    check("t2_err_bad",  32'(err_bad), 0);
    check("t2_sel_bad",  32'(sel_bad), 0);
    check("t2_vec_bad",  32'(vec_bad), 0);
    check("t2_terr",     32'(terr_a), 15);
    tick(); tick();
    check("t2_terr_held", 32'(terr_a), 15);

    // num_vec = 0: back-to-back reports, no injection.
    num_vec = 16'd0;
    run_a(20, 16'd0);
    check("t3_done_cyc", 32'(done_cyc), 7);
    check("t3_pulses",   32'(pulses), 5);
    check("t3_idx_bad",  32'(idx_bad), 0);
    check("t3_err_bad",  32'(err_bad), 0);
    check("t3_inj_seen", 32'(inj_seen), 0);
    check("t3_terr",     32'(terr_a), 0);
    tick();

    // Saturation with 4-bit counters.
    num_vec = 16'd20; seed = 5'b00011;
    done_cyc = 0; pulses = 0; err_bad = 0;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
      tick();
      start_b = 1'b0;
      if (nv_b === 1'b1) begin
        if (nerr_b !== 4'd15) err_bad++;
        pulses++;
      end
      if (done_b === 1'b1) done_cyc = cyc;
    end
    check("t4_done_cyc", 32'(done_cyc), 207);
    check("t4_pulses",   32'(pulses), 5);
    check("t4_err_bad",  32'(err_bad), 0);
    check("t4_terr",     32'(terr_b), 15);
    tick();

    // LAT=2: abort in node 2, then restart from scratch.
    num_vec = 16'd3;
    pulses = 0;
    start_c = 1'b1;
    for (int cyc = 1; cyc <= 29; cyc++) begin
      tick();
      start_c = 1'b0;
      if (nv_c === 1'b1) pulses++;
    end
    check("t5_pulses_pre", 32'(pulses), 2);
    check("t5_inj_pre",    32'(inj_c), 1);
    check("t5_sel_pre",    32'(sel_c), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy_abort", 32'(busy_c), 0);
    check("t5_inj_abort",  32'(inj_c), 0);
    done_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done_c === 1'b1) done_cyc = cyc;
    end
    check("t5_no_done", 32'(done_cyc), 0);
    done_cyc = 0; pulses = 0; idx_bad = 0; err_bad = 0;
    start_c = 1'b1;
    for (int cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
      tick();
      start_c = 1'b0;
      if (cyc == 2) check("t5_terr_clr", 32'(terr_c), 0);
      if (nv_c === 1'b1) begin
        if (idx_c !== 3'(pulses)) idx_bad++;
        if (nerr_c !== 16'd3) err_bad++;
        pulses++;
      end
      if (done_c === 1'b1) done_cyc = cyc;
    end
    check("t5_done_cyc", 32'(done_cyc), 67);
    check("t5_idx_bad",  32'(idx_bad), 0);
    check("t5_err_bad",  32'(err_bad), 0);
    check("t5_terr",     32'(terr_c), 15);
    tick();

    // Reset pulse mid-campaign.
    seed = 5'b10101;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) tick();
    check("t6_terr_pre", 32'(terr_a), 3);
    check("t6_busy_pre", 32'(busy_a), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_zero_a("t6");
    tick();
    check("t6_busy_idle", 32'(busy_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
